// File: rtl/jtframe_bank_arb.sv
// jtframe_bank_arb: round-robin arbiter sharing one SDRAM bank port among N requesters.
// One bank transfer at a time; read data is held per requester until its next read lands.
module jtframe_bank_arb #(
  parameter int N  = 4,
  parameter int AW = 22,
  parameter int DW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req_rd,
  input  logic [N-1:0]    req_wr,
  input  logic [N*AW-1:0] req_addr,
  input  logic [N*DW-1:0] req_din,
  input  logic [N*2-1:0]  req_dsn,
  output logic [N*DW-1:0] req_dout,
  output logic [N-1:0]    req_ok,
  output logic [AW-1:0]   ba_addr,
  output logic            ba_rd,
  output logic            ba_wr,
  output logic [DW-1:0]   ba_din,
  output logic [1:0]      ba_dsn,
  input  logic            ba_ack,
  input  logic            ba_dok,
  input  logic            ba_rdy,
  input  logic [DW-1:0]   sdram_dout,
  output logic            busy
);
  localparam int SW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] { IDLE, REQ, WAIT } state_t;
  state_t state, state_nxt;

  logic [SW-1:0] ptr, sel, gnt_idx;
  logic [N-1:0]  mask, active;
  logic          gnt_vld, done, xfer_wr;
  logic [AW-1:0] addr_a [N];
  logic [DW-1:0] din_a  [N];
  logic [1:0]    dsn_a  [N];
  logic [DW-1:0] dout_q [N];

  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign addr_a[i]            = req_addr[i*AW +: AW];
    assign din_a[i]             = req_din[i*DW +: DW];
    assign dsn_a[i]             = req_dsn[i*2 +: 2];
    assign req_dout[i*DW +: DW] = dout_q[i];
  end

  assign active = (req_rd | req_wr) & ~mask;
  assign busy   = state != IDLE;

  // First active requester at or after ptr, wrapping modulo N
  always_comb begin
    logic [SW:0] pos;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    pos     = '0;
    for (int k = 0; k < N; k++) begin
      pos = {1'b0, ptr} + (SW+1)'(k);
      if (pos >= (SW+1)'(N)) pos = pos - (SW+1)'(N);
      if (!gnt_vld && active[pos[SW-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = pos[SW-1:0];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    case (state)
      IDLE: if (gnt_vld) state_nxt = REQ;
      REQ:  if (ba_ack) begin
              if (ba_rdy) begin
                state_nxt = IDLE;
                done      = 1'b1;
              end else begin
                state_nxt = WAIT;
              end
            end
      WAIT: if (ba_rdy) begin
              state_nxt = IDLE;
              done      = 1'b1;
            end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      sel     <= '0;
      ptr     <= '0;
      mask    <= '0;
      xfer_wr <= 1'b0;
      ba_addr <= '0;
      ba_din  <= '0;
      ba_dsn  <= 2'b11;
      ba_rd   <= 1'b0;
      ba_wr   <= 1'b0;
      req_ok  <= '0;
      for (int i = 0; i < N; i++) dout_q[i] <= '0;
    end else begin
      state  <= state_nxt;
      req_ok <= '0;
      mask   <= '0;
      if (state == IDLE && gnt_vld) begin
        sel     <= gnt_idx;
        ba_addr <= addr_a[gnt_idx];
        ba_din  <= din_a[gnt_idx];
        ba_dsn  <= dsn_a[gnt_idx];
        xfer_wr <= req_wr[gnt_idx];
        ba_wr   <= req_wr[gnt_idx];
        ba_rd   <= ~req_wr[gnt_idx];
      end
      if (state != IDLE && ba_dok && !xfer_wr) dout_q[sel] <= sdram_dout;
      if (state == REQ && ba_ack) begin
        ba_rd <= 1'b0;
        ba_wr <= 1'b0;
      end
      // Mask keeps the finished requester out for the cycle it spends dropping its request
      if (done) begin
        req_ok[sel] <= 1'b1;
        mask[sel]   <= 1'b1;
        ptr         <= (sel == SW'(N-1)) ? '0 : sel + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_jtframe_bank_arb.sv
// Bench for jtframe_bank_arb: directed scenarios then random requester/bank traffic,
// all outputs compared every cycle with a transaction-level reference model.
module tb_jtframe_bank_arb;
  localparam int N  = 4;
  localparam int AW = 22;
  localparam int DW = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_rd = '0, req_wr = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_din = '0;
  logic [N*2-1:0]  req_dsn = '1;
  logic [N*DW-1:0] req_dout;
  logic [N-1:0]    req_ok;
  logic [AW-1:0]   ba_addr;
  logic            ba_rd, ba_wr;
  logic [DW-1:0]   ba_din;
  logic [1:0]      ba_dsn;
  logic            ba_ack = 1'b0, ba_dok = 1'b0, ba_rdy = 1'b0;
  logic [DW-1:0]   sdram_dout = '0;
  logic            busy;

  jtframe_bank_arb #(.N(N), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .req_rd(req_rd), .req_wr(req_wr), .req_addr(req_addr), .req_din(req_din),
    .req_dsn(req_dsn), .req_dout(req_dout), .req_ok(req_ok),
    .ba_addr(ba_addr), .ba_rd(ba_rd), .ba_wr(ba_wr), .ba_din(ba_din), .ba_dsn(ba_dsn),
    .ba_ack(ba_ack), .ba_dok(ba_dok), .ba_rdy(ba_rdy), .sdram_dout(sdram_dout),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Requester-side data
  logic [AW-1:0] r_addr [N];
  logic [DW-1:0] r_din  [N];
  logic [1:0]    r_dsn  [N];

  // Reference model: transfer in flight (0 none, 1 awaiting ack, 2 awaiting rdy)
  int            m_phase, m_sel, m_ptr, m_excl;
  logic          m_wr, m_rd_o, m_wr_o;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_din;
  logic [1:0]    m_dsn;
  logic [N-1:0]  m_ok;
  logic [DW-1:0] m_dout [N];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_phase = 0; m_sel = 0; m_ptr = 0; m_excl = -1;
    m_wr = 1'b0; m_rd_o = 1'b0; m_wr_o = 1'b0;
    m_addr = '0; m_din = '0; m_dsn = 2'b11; m_ok = '0;
    for (int i = 0; i < N; i++) m_dout[i] = '0;
  endfunction

  // One clock edge of the arbiter's externally visible behaviour
  function automatic void model_step(input logic [N-1:0] rr, input logic [N-1:0] rw,
                                     input logic ack, input logic dok, input logic rdy,
                                     input logic [DW-1:0] data);
    int  win, idx;
    bit  fin;
    m_ok = '0;
    if (m_phase == 0) begin
      win = -1;
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (win < 0 && (rr[idx] || rw[idx]) && idx != m_excl) win = idx;
      end
      m_excl = -1;
      if (win >= 0) begin
        m_sel = win; m_wr = rw[win]; m_rd_o = !rw[win]; m_wr_o = rw[win];
        m_addr = r_addr[win]; m_din = r_din[win]; m_dsn = r_dsn[win];
        m_phase = 1;
      end
    end else begin
      if (dok && !m_wr) m_dout[m_sel] = data;
      fin = (m_phase == 2 && rdy) || (m_phase == 1 && ack && rdy);
      if (m_phase == 1 && ack) begin
        m_rd_o = 1'b0; m_wr_o = 1'b0; m_phase = 2;
      end
      if (fin) begin
        m_ok[m_sel] = 1'b1;
        m_ptr  = (m_sel + 1) % N;
        m_excl = m_sel;
        m_phase = 0;
      end
    end
  endfunction

  task automatic check_all();
    logic [N*DW-1:0] exp_dout;
    for (int i = 0; i < N; i++) exp_dout[i*DW +: DW] = m_dout[i];
    chk("busy",     64'(busy),     64'(m_phase != 0));
    chk("ba_rd",    64'(ba_rd),    64'(m_rd_o));
    chk("ba_wr",    64'(ba_wr),    64'(m_wr_o));
    chk("ba_addr",  64'(ba_addr),  64'(m_addr));
    chk("ba_din",   64'(ba_din),   64'(m_din));
    chk("ba_dsn",   64'(ba_dsn),   64'(m_dsn));
    chk("req_ok",   64'(req_ok),   64'(m_ok));
    chk("req_dout", 64'(req_dout), 64'(exp_dout));
  endtask

  // Called on a falling edge: drive inputs for the next rising edge, then check results
  task automatic cycle(input logic [N-1:0] rr, input logic [N-1:0] rw,
                       input logic ack, input logic dok, input logic rdy,
                       input logic [DW-1:0] data);
    req_rd = rr; req_wr = rw;
    ba_ack = ack; ba_dok = dok; ba_rdy = rdy; sdram_dout = data;
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW] = r_addr[i];
      req_din[i*DW +: DW]  = r_din[i];
      req_dsn[i*2 +: 2]    = r_dsn[i];
    end
    model_step(rr, rw, ack, dok, rdy, data);
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    chk("rst_dsn", 64'(ba_dsn), 64'(2'b11));
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Read transfer: grant cycle with rg, then ack, then dok+rdy; requester id must win
  task automatic xfer(input logic [N-1:0] rg, input logic [N-1:0] rest, input int id);
    logic [DW-1:0] word;
    word = DW'($urandom);
    cycle(rg, '0, 1'b0, 1'b0, 1'b0, '0);
    chk("grant_addr", 64'(ba_addr), 64'(r_addr[id]));
    chk("grant_rd", 64'(ba_rd), 64'(1));
    cycle(rest, '0, 1'b1, 1'b0, 1'b0, '0);
    cycle(rest, '0, 1'b0, 1'b1, 1'b1, word);
    chk("xfer_ok", 64'(req_ok), 64'(1 << id));
    chk("xfer_dout", 64'(req_dout[id*DW +: DW]), 64'(word));
  endtask

  initial begin
    logic [N-1:0]  rv, wv;
    logic [DW-1:0] old;
    bit            pend [N];
    bit            hold [N];
    int            gap  [N];
    int            bcnt, t;
    logic          ack, dok, rdy;

    for (int i = 0; i < N; i++) begin
      r_addr[i] = AW'(22'h0A0 + 22'h111 * i);
      r_din[i]  = DW'(16'h1000 + i);
      r_dsn[i]  = 2'b00;
    end
    r_addr[2] = 22'h1234;
    r_addr[3] = 22'h3FFFFF;
    model_reset();
    @(negedge clk);
    do_reset();

    // Single read on requester 2
    cycle(4'b0100, '0, 1'b0, 1'b0, 1'b0, '0);
    chk("rd_req", 64'(ba_rd), 64'(1));
    chk("rd_addr", 64'(ba_addr), 64'(22'h1234));
    cycle(4'b0100, '0, 1'b0, 1'b0, 1'b0, '0);
    cycle(4'b0100, '0, 1'b0, 1'b0, 1'b0, '0);
    cycle(4'b0100, '0, 1'b1, 1'b0, 1'b0, '0);
    cycle(4'b0100, '0, 1'b0, 1'b1, 1'b0, 16'hBEEF);
    cycle(4'b0100, '0, 1'b0, 1'b0, 1'b1, '0);
    chk("rd_ok", 64'(req_ok), 64'(4'b0100));
    chk("rd_dout", 64'(req_dout[2*DW +: DW]), 64'(16'hBEEF));
    cycle(4'b0100, '0, 1'b0, 1'b0, 1'b0, '0);
    chk("rd_mask", 64'(busy), 64'(0));
    cycle('0, '0, 1'b0, 1'b0, 1'b0, '0);

    // All four from reset, then 1 and 0 re-raised
    do_reset();
    xfer(4'b1111, 4'b1111, 0);
    xfer(4'b1111, 4'b1110, 1);
    xfer(4'b1110, 4'b1100, 2);
    xfer(4'b1100, 4'b1000, 3);
    xfer(4'b1011, 4'b0011, 0);
    xfer(4'b0011, 4'b0010, 1);
    cycle(4'b0010, '0, 1'b0, 1'b0, 1'b0, '0);
    chk("rr_mask", 64'(busy), 64'(0));
    cycle('0, '0, 1'b0, 1'b0, 1'b0, '0);

    // Requester 3 holds its request across three transfers
    for (int n = 0; n < 3; n++) begin
      xfer(4'b1000, 4'b1000, 3);
      cycle(4'b1000, '0, 1'b0, 1'b0, 1'b0, '0);
      chk("persist_mask", 64'(busy), 64'(0));
      chk("persist_rd", 64'(ba_rd), 64'(0));
    end
    cycle('0, '0, 1'b0, 1'b0, 1'b0, '0);

    // Write on requester 1 with a stray dok
    r_din[1] = 16'h55AA;
    r_dsn[1] = 2'b01;
    old = m_dout[1];
    cycle('0, 4'b0010, 1'b0, 1'b0, 1'b0, '0);
    chk("wr_req", 64'(ba_wr), 64'(1));
    chk("wr_din", 64'(ba_din), 64'(16'h55AA));
    chk("wr_dsn", 64'(ba_dsn), 64'(2'b01));
    cycle('0, 4'b0010, 1'b1, 1'b0, 1'b0, '0);
    cycle('0, 4'b0010, 1'b0, 1'b1, 1'b0, 16'h1111);
    chk("wr_dok", 64'(req_dout[1*DW +: DW]), 64'(old));
    cycle('0, 4'b0010, 1'b0, 1'b0, 1'b1, '0);
    chk("wr_ok", 64'(req_ok), 64'(4'b0010));
    cycle('0, '0, 1'b0, 1'b0, 1'b0, '0);

    // ack and rdy together
    cycle(4'b0001, '0, 1'b0, 1'b0, 1'b0, '0);
    cycle(4'b0001, '0, 1'b1, 1'b1, 1'b1, 16'hA5A5);
    chk("ackrdy_ok", 64'(req_ok), 64'(4'b0001));
    chk("ackrdy_busy", 64'(busy), 64'(0));
    chk("ackrdy_dout", 64'(req_dout[0 +: DW]), 64'(16'hA5A5));
    cycle('0, '0, 1'b0, 1'b0, 1'b0, '0);

    // Reset while waiting for rdy
    cycle(4'b0100, '0, 1'b0, 1'b0, 1'b0, '0);
    cycle(4'b0100, '0, 1'b1, 1'b0, 1'b0, '0);
    chk("mid_busy", 64'(busy), 64'(1));
    rst = 1'b1;
    #1;
    chk("rst_rd", 64'(ba_rd), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_dout", 64'(req_dout), 64'(0));
    do_reset();
    cycle(4'b0101, '0, 1'b0, 1'b0, 1'b0, '0);
    chk("post_rst_grant", 64'(ba_addr), 64'(r_addr[0]));
    cycle(4'b0101, '0, 1'b1, 1'b0, 1'b1, '0);
    cycle('0, '0, 1'b0, 1'b0, 1'b0, '0);

    // Random traffic
    rv = '0; wv = '0; bcnt = 0;
    for (int i = 0; i < N; i++) begin
      pend[i] = 0; hold[i] = 0; gap[i] = $urandom_range(0, 3);
    end
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (hold[i]) begin
          hold[i] = 0; rv[i] = 1'b0; wv[i] = 1'b0;
        end else if (pend[i] && m_ok[i]) begin
          pend[i] = 0; gap[i] = $urandom_range(0, 4);
          if ($urandom_range(0, 1) == 1) hold[i] = 1;
          else begin rv[i] = 1'b0; wv[i] = 1'b0; end
        end else if (!pend[i]) begin
          if (gap[i] == 0) begin
            pend[i] = 1;
            r_addr[i] = AW'($urandom);
            r_din[i]  = DW'($urandom);
            r_dsn[i]  = 2'($urandom);
            t = $urandom_range(0, 2);
            rv[i] = (t != 1); wv[i] = (t != 0);
          end else gap[i]--;
        end else if (m_phase != 0 && m_sel == i && $urandom_range(0, 15) == 0) begin
          rv[i] = 1'b0; wv[i] = 1'b0;
        end
      end
      ack = 1'b0; dok = 1'b0; rdy = 1'b0;
      if (m_phase == 1) begin
        if (bcnt > 0) bcnt--;
        else begin
          ack = 1'b1;
          if ($urandom_range(0, 3) == 0) begin
            rdy = 1'b1; dok = 1'($urandom_range(0, 1));
          end
          bcnt = $urandom_range(0, 3);
        end
      end else if (m_phase == 2) begin
        dok = ($urandom_range(0, 2) == 0);
        if (bcnt > 0) bcnt--;
        else begin
          rdy = 1'b1; bcnt = $urandom_range(0, 3);
        end
      end else begin
        ack = ($urandom_range(0, 7) == 0);
        dok = ($urandom_range(0, 7) == 0);
        rdy = ($urandom_range(0, 7) == 0);
      end
      cycle(rv, wv, ack, dok, rdy, DW'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/jtframe_bank_arb.md
# jtframe_bank_arb

Round-robin arbiter that shares one SDRAM bank port (addr/rd/wr/ack/dok/rdy handshake towards the SDRAM controller) among up to N game-side requesters. It sits between the game core's ROM/RAM request logic and one `baX_*` bank port of the frame's SDRAM controller. It serialises one transfer at a time and latches read data per requester, so each requester sees a stable word until its next transfer.

## Interface
Parameters:
- `N`, 4: number of requesters (2..8).
- `AW`, 22: address width (matches `SDRAMW`).
- `DW`, 16: data width.

Ports:
- `clk` in 1: single clock, same as the SDRAM controller clock.
- `rst` in 1: reset, asynchronous, active-high.
- `req_rd` in N: per-requester read request, level; held until `req_ok[i]`.
- `req_wr` in N: per-requester write request, level; held until `req_ok[i]`. If `req_rd[i]` and `req_wr[i]` are both high, the transfer is a write.
- `req_addr` in N*AW: packed addresses, requester i at `[i*AW +: AW]`.
- `req_din` in N*DW: packed write data.
- `req_dsn` in N*2: packed byte enables, active-low.
- `req_dout` out N*DW: packed latched read data per requester.
- `req_ok` out N: one-cycle pulse when requester i's transfer completes.
- `ba_addr` out AW: address to the bank.
- `ba_rd` out 1: read request to the bank.
- `ba_wr` out 1: write request to the bank.
- `ba_din` out DW: write data to the bank.
- `ba_dsn` out 2: byte enables to the bank.
- `ba_ack` in 1: one-cycle pulse; the bank has accepted the request.
- `ba_dok` in 1: `sdram_dout` is valid this cycle.
- `ba_rdy` in 1: one-cycle pulse; the transfer is finished.
- `sdram_dout` in DW: bank read data.
- `busy` out 1: high while the FSM is not in IDLE.

## Operation
- FSM states:
  - IDLE to REQ when any unmasked `req_rd|req_wr` is high.
  - REQ to WAIT when `ba_ack` is high.
  - WAIT to IDLE when `ba_rdy` is high.
- Grant in IDLE:
  - Scan starts at pointer `ptr` and wraps modulo N; the first active requester wins and becomes `sel`.
  - On that edge, register `ba_addr`, `ba_din` and `ba_dsn` from `sel`. Assert `ba_rd` or `ba_wr` according to the request type.
- REQ:
  - Hold `ba_rd`/`ba_wr` and the address until `ba_ack` is sampled high.
  - On that edge, clear `ba_rd`/`ba_wr` and go to WAIT.
- `ba_ack` and `ba_rdy` high in the same cycle in REQ: complete directly and go to IDLE, with the same actions as WAIT+rdy.
- Read data capture:
  - On any cycle in REQ or WAIT with `ba_dok` high on a read, write `sdram_dout` into the `req_dout` slot of `sel`.
  - Later `ba_dok` pulses overwrite the slot; the last word wins.
  - `ba_dok` on a write is ignored.
- Completion (`ba_rdy` high in WAIT):
  - Pulse `req_ok[sel]` for 1 cycle.
  - Set `ptr <= (sel+1) mod N`.
  - Set the one-cycle mask bit `mask[sel]` and go to IDLE.
- Mask: in the IDLE cycle that immediately follows completion, requester `sel` is excluded from arbitration. This covers the cycle in which the requester is still lowering its request on seeing `req_ok`. The mask clears after that one cycle.
- Request drops mid-transfer: the transfer still runs to completion, data is latched and `req_ok` still pulses. The FSM never aborts a bank transaction.
- `ba_ack`/`ba_dok`/`ba_rdy` in IDLE: ignored.
- `req_dout` slots change only on captured `ba_dok`; they are never cleared except by reset.

## Timing
- Reset values:
  - FSM in IDLE.
  - All outputs zero: `ba_addr`, `ba_din`, `req_dout`, `req_ok`, `ba_rd`, `ba_wr` and `busy` are 0.
  - `ba_dsn` = 2'b11.
  - `ptr` = 0 and `mask` = 0.
- Assertion of `rst` at any point, including mid-transfer, returns to these values immediately. The SDRAM controller is reset by the same `rst`.
- Request latency: `req_rd[i]` sampled high at edge k gives `ba_rd` = 1 after edge k (1 cycle).
- Request release: `ba_ack` sampled at edge m gives `ba_rd`/`ba_wr` = 0 after edge m.
- Completion latency: `ba_rdy` sampled at edge r gives `req_ok[sel]` = 1 during cycle r..r+1, with the FSM in IDLE.
- Next grant: earliest after edge r+1, to a different requester. The same requester can be granted again after edge r+2 at the earliest.
- Minimum turnaround between bank requests is 1 idle cycle.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- Single read: `req_rd[2]` with addr 0x1234. Expect `ba_rd` = 1 one cycle later with `ba_addr` = 0x1234. Drive `ack` 3 cycles later, `dok` with 0xBEEF, then `rdy`. Expect `req_dout` slot 2 = 0xBEEF and a 1-cycle `req_ok[2]`.
- Simultaneous requests: all 4 `req_rd` high from reset. Expect grant order 0,1,2,3. Then re-raise only 1 and 0: order is 0 (`ptr` = 0 after wrap), then 1.
- Single persistent requester: keep `req_rd[3]` high for 3 transfers. Expect exactly 3 bank requests, each separated by ≥2 cycles from the previous `req_ok[3]`, and no duplicate grant during the mask cycle.
- Write: `req_wr[1]` with din 0x55AA and dsn 2'b01. Expect `ba_wr` = 1, `ba_din` = 0x55AA, `ba_dsn` = 01. A `ba_dok` during the write leaves `req_dout` slot 1 unchanged.
- `ack` and `rdy` in the same cycle: expect `req_ok` to pulse and the FSM to return to IDLE without entering WAIT.
- Reset mid-transfer: assert `rst` in WAIT. Expect `ba_rd` = 0, `busy` = 0 and `req_dout` = 0 immediately. After release, a new request to requester 0 is granted first (`ptr` = 0).
